// File: rtl/traffic_display_driver.sv
// Lamp and countdown display stage behind the traffic light controller.
// Tracks seconds left in the current phase and multiplexes it onto a 2-digit 7-segment display.
module traffic_display_driver #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] light_in,
  input  logic [1:0] mode,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       fault
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_FAULT  = 2'b11;

  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Compare chain instead of a divider; input is bounded to 0..99.
  function automatic logic [3:0] bcd_tens(input logic [6:0] r);
    bcd_tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (int'(r) >= i * 10) bcd_tens = 4'(i);
    end
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] r, input logic [3:0] t);
    bcd_ones = 4'(r - 7'(int'(t) * 10));
  endfunction

  logic [1:0]    prev_light_q, prev_light_d;
  logic [6:0]    remaining_q, remaining_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic          lamp_red_q, lamp_red_d;
  logic          lamp_yellow_q, lamp_yellow_d;
  logic          lamp_green_q, lamp_green_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  logic          fault_q, fault_d;

  logic       is_fault, change;
  logic [1:0] mode_eff;
  logic [6:0] load_val;
  logic [3:0] tens, ones;

  always_comb begin
    is_fault = (light_in == L_FAULT);
    change   = (light_in != prev_light_q);
    mode_eff = (mode == 2'b11) ? 2'b00 : mode;

    case (light_in)
      L_GREEN:  load_val = (mode_eff == 2'b01) ? 7'd55 : (mode_eff == 2'b10) ? 7'd85 : 7'd25;
      L_YELLOW: load_val = 7'd5;
      L_RED:    load_val = (mode_eff == 2'b01) ? 7'd60 : (mode_eff == 2'b10) ? 7'd90 : 7'd30;
      default:  load_val = 7'd0;
    endcase

    prev_light_d = light_in;
    remaining_d  = remaining_q;
    if (change)                         remaining_d = load_val;
    else if (tick && remaining_q != 0)  remaining_d = remaining_q - 7'd1;

    blink_d = is_fault ? (blink_q ^ tick) : 1'b0;

    lamp_red_d    = (light_in == L_RED);
    lamp_green_d  = (light_in == L_GREEN);
    lamp_yellow_d = (light_in == L_YELLOW) || (is_fault && blink_d);
    fault_d       = is_fault;

    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    dig_sel_d = (cnt_q == CNT_MAX) ? ~dig_sel_q : dig_sel_q;

    // seg is built from next-state values so it lands in the same edge as dig_sel.
    tens = bcd_tens(remaining_d);
    ones = bcd_ones(remaining_d, tens);
    if (fault_d)                        seg_d = 7'h40;
    else if (dig_sel_d == SEL_TENS)     seg_d = (tens == 4'd0) ? 7'h00 : seg7(tens);
    else                                seg_d = seg7(ones);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_light_q  <= L_RED;
      remaining_q   <= '0;
      cnt_q         <= '0;
      blink_q       <= 1'b0;
      lamp_red_q    <= 1'b1;
      lamp_yellow_q <= 1'b0;
      lamp_green_q  <= 1'b0;
      seg_q         <= '0;
      dig_sel_q     <= SEL_ONES;
      fault_q       <= 1'b0;
    end else begin
      prev_light_q  <= prev_light_d;
      remaining_q   <= remaining_d;
      cnt_q         <= cnt_d;
      blink_q       <= blink_d;
      lamp_red_q    <= lamp_red_d;
      lamp_yellow_q <= lamp_yellow_d;
      lamp_green_q  <= lamp_green_d;
      seg_q         <= seg_d;
      dig_sel_q     <= dig_sel_d;
      fault_q       <= fault_d;
    end
  end

  assign lamp_red    = lamp_red_q;
  assign lamp_yellow = lamp_yellow_q;
  assign lamp_green  = lamp_green_q;
  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;
  assign fault       = fault_q;

endmodule
